pool_layer_generic: RTL and testbench

POOL_LAYER_GENERIC -- requirements
Module: pool_layer_generic

---
 rtl/pool_layer_generic.sv | 150 +++++++++++++++
 tb/tb_pool_layer_generic.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_layer_generic.sv
// Streaming max/average pooling over a raster, channel-major pixel stream.
// One line buffer entry per window column accumulates partial results.
module pool_layer_generic #(
  parameter int IMG_SIZE   = 24,
  parameter int CHANNELS   = 2,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         relu_en,
  input  logic                         data_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         busy,
  output logic                         result_valid,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] out_channel,
  output logic                         finish
);

  localparam int LOG2P = $clog2(POOL_SIZE);
  localparam int ACC_W = DATA_WIDTH + 2 * LOG2P;
  localparam int NWIN  = IMG_SIZE / POOL_SIZE;
  localparam int CW    = $clog2(IMG_SIZE);
  localparam int CHW   = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]  LAST_PIX = CW'(IMG_SIZE - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(CHANNELS - 1);

  if (!(POOL_SIZE == 2 || POOL_SIZE == 4) ||
      (IMG_SIZE % POOL_SIZE) != 0) begin : g_bad_param
    $error("pool_layer_generic: unsupported POOL_SIZE/IMG_SIZE");
  end

  logic [1:0]     state;
  logic [CW-1:0]  col;
  logic [CW-1:0]  row;
  logic [CHW-1:0] ch;
  logic           mode_q;
  logic           relu_q;

  logic signed [ACC_W-1:0] lb [NWIN];

  logic                    accept;
  logic                    first;
  logic                    last;
  logic                    col_end;
  logic                    row_end;
  logic                    ch_end;
  logic [CW-LOG2P-1:0]     idx;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] cur;
  logic signed [ACC_W-1:0] comb;
  logic signed [ACC_W-1:0] pooled;

  assign busy    = (state == S_RUN);
  assign accept  = busy && data_valid;
  assign idx     = col[CW-1:LOG2P];
  assign first   = ~|col[LOG2P-1:0] && ~|row[LOG2P-1:0];
  assign last    = &col[LOG2P-1:0] && &row[LOG2P-1:0];
  assign col_end = (col == LAST_PIX);
  assign row_end = (row == LAST_PIX);
  assign ch_end  = (ch == LAST_CH);

  always_comb begin
    ext    = {{(2 * LOG2P){data_in[DATA_WIDTH-1]}}, data_in};
    cur    = lb[idx];
    comb   = '0;
    pooled = '0;
    if (mode_q) begin
      comb = cur + ext;
    end else begin
      comb = (ext > cur) ? ext : cur;
    end
    // Average divides by P*P with an arithmetic shift: floor toward -inf.
    pooled = mode_q ? (comb >>> (2 * LOG2P)) : comb;
    if (relu_q && pooled < 0) begin
      pooled = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      ch           <= '0;
      mode_q       <= 1'b0;
      relu_q       <= 1'b0;
      result_valid <= 1'b0;
      finish       <= 1'b0;
      data_out     <= '0;
      out_channel  <= '0;
      for (int i = 0; i < NWIN; i++) begin
        lb[i] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      finish       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            relu_q <= relu_en;
            col    <= '0;
            row    <= '0;
            ch     <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            lb[idx] <= first ? ext : comb;
            if (last) begin
              result_valid <= 1'b1;
              data_out     <= pooled[DATA_WIDTH-1:0];
              out_channel  <= ch;
            end
            if (col_end) begin
              col <= '0;
              if (row_end) begin
                row <= '0;
                ch  <= ch + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
            if (col_end && row_end && ch_end) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          finish <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer_generic.sv
// Scoreboard bench for pool_layer_generic: driver queues expected windows,
// a negedge monitor pops and compares each result_valid pulse.
module tb_pool_layer_generic;

  localparam int N    = 24;
  localparam int C    = 2;
  localparam int P    = 2;
  localparam int NOUT = C * (N / P) * (N / P);

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               mode;
  logic               relu_en;
  logic               data_valid;
  logic signed [15:0] data_in;
  logic               busy;
  logic               result_valid;
  logic signed [15:0] data_out;
  logic [0:0]         out_channel;
  logic               finish;

  always #5 clk = ~clk;

  pool_layer_generic dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .relu_en      (relu_en),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .busy         (busy),
    .result_valid (result_valid),
    .data_out     (data_out),
    .out_channel  (out_channel),
    .finish       (finish)
  );

  int n_checks = 0;
  int n_err    = 0;
  int fr [C][N][N];
  int exp_d [$];
  int exp_c [$];
  int cap_d [NOUT];
  int cap_c [NOUT];
  int cap_n    = 0;
  int n_finish = 0;
  bit prev_rv  = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int win_res(input int ch, input int wr, input int wc,
                                 input bit md, input bit rl);
    int acc;
    int v;
    acc = md ? 0 : -1000000;
    for (int dr = 0; dr < P; dr++) begin
      for (int dc = 0; dc < P; dc++) begin
        v = fr[ch][wr * P + dr][wc * P + dc];
        if (md) acc = acc + v;
        else if (v > acc) acc = v;
      end
    end
    if (md) acc = acc >>> 2;
    if (rl && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic fill_ramp;
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          fr[ch][r][c] = r * N + c;
  endtask

  task automatic fill_const(input int v);
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          fr[ch][r][c] = v;
  endtask

  initial begin : monitor
    int ed;
    int ec;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (exp_d.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_result: got data %0d ch %0d, expected none",
                   data_out, out_channel);
        end else begin
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          chk("data_out", int'(data_out), ed);
          chk("out_channel", int'(out_channel), ec);
          if (cap_n < NOUT) begin
            cap_d[cap_n] = int'(data_out);
            cap_c[cap_n] = int'(out_channel);
          end
          cap_n++;
        end
      end
      if (finish === 1'b1) begin
        n_finish++;
        chk("finish_after_last", int'(prev_rv && exp_d.size() == 0), 1);
      end
      prev_rv = (result_valid === 1'b1);
    end
  end

  task automatic run_frame(input bit md, input bit rl, input int gap,
                           input int abort_at, input bit mid_start);
    int f0;
    bit done;
    int ch;
    int r;
    int c;
    cap_n = 0;
    f0 = n_finish;
    start = 1'b1;
    mode = md;
    relu_en = rl;
    tick;
    start = 1'b0;
    mode = ~md;
    relu_en = ~rl;
    chk("busy_run", int'(busy), 1);
    for (int k = 0; k < C * N * N; k++) begin
      if (k == abort_at) break;
      ch = k / (N * N);
      r = (k / N) % N;
      c = k % N;
      for (int g = 0; g < gap; g++) begin
        data_valid = 1'b0;
        tick;
      end
      data_valid = 1'b1;
      data_in = 16'(fr[ch][r][c]);
      start = mid_start && (k == 500);
      if (r % P == P - 1 && c % P == P - 1) begin
        exp_d.push_back(win_res(ch, r / P, c / P, md, rl));
        exp_c.push_back(ch);
      end
      tick;
    end
    data_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) begin
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_result_valid", int'(result_valid), 0);
      repeat (30) tick;
      chk("abort_no_finish", n_finish - f0, 0);
      chk("abort_queue_empty", exp_d.size(), 0);
      chk("abort_result_count", cap_n, 72);
    end else begin
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        tick;
        if (n_finish != f0) done = 1'b1;
      end
      chk("finish_seen", int'(done), 1);
      chk("finish_one_cycle", int'(finish), 0);
      chk("busy_idle", int'(busy), 0);
      chk("result_count", cap_n, NOUT);
      chk("queue_empty", exp_d.size(), 0);
    end
  endtask

  task automatic ramp_spots(input string tag);
    chk({tag, "_out0"}, cap_d[0], 25);
    chk({tag, "_out1"}, cap_d[1], 27);
    chk({tag, "_out12"}, cap_d[12], 73);
    chk({tag, "_out144"}, cap_d[144], 25);
    chk({tag, "_ch143"}, cap_c[143], 0);
    chk({tag, "_ch144"}, cap_c[144], 1);
  endtask

  initial begin : driver
    reset = 1'b1;
    start = 1'b1;
    mode = 1'b0;
    relu_en = 1'b0;
    data_valid = 1'b1;
    data_in = '0;
    tick;
    tick;
    reset = 1'b0;
    start = 1'b0;
    data_valid = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_out_channel", int'(out_channel), 0);
    repeat (3) tick;

    fill_ramp();
    run_frame(1'b0, 1'b0, 0, -1, 1'b0);
    ramp_spots("max");

    run_frame(1'b0, 1'b0, 2, -1, 1'b0);
    ramp_spots("gap");

    fill_const(0);
    fr[0][0][0] = 1;  fr[0][0][1] = 2;  fr[0][1][0] = 2;  fr[0][1][1] = 2;
    fr[0][0][2] = -1; fr[0][0][3] = -2; fr[0][1][2] = -2; fr[0][1][3] = -2;
    fr[0][0][4] = -3; fr[0][0][5] = -3; fr[0][1][4] = -3; fr[0][1][5] = -3;
    run_frame(1'b1, 1'b0, 0, -1, 1'b0);
    chk("avg_pos", cap_d[0], 1);
    chk("avg_neg", cap_d[1], -2);
    chk("avg_m3", cap_d[2], -3);

    fill_const(-100);
    run_frame(1'b0, 1'b1, 0, -1, 1'b0);
    chk("relu_first", cap_d[0], 0);
    chk("relu_last", cap_d[NOUT-1], 0);
    fr[0][1][0] = 50;
    run_frame(1'b0, 1'b1, 0, -1, 1'b0);
    chk("relu_pos", cap_d[0], 50);

    fill_ramp();
    fr[0][0][0] = -32768; fr[0][0][1] = 32767;
    fr[0][1][0] = 0;      fr[0][1][1] = -1;
    run_frame(1'b0, 1'b0, 0, -1, 1'b1);
    chk("ext_max", cap_d[0], 32767);
    chk("ext_out1", cap_d[1], 27);

    fill_ramp();
    run_frame(1'b0, 1'b0, 0, 300, 1'b0);
    run_frame(1'b0, 1'b0, 0, -1, 1'b0);
    ramp_spots("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
